// File: rtl/elevator_pkg.sv
// Shared state encoding, direction constants and sizing helper for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the MOVE and DOOR phases of the car controller.
module elev_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: load wins over decrement, and the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller: one decision cycle in IDLE, timed floor-to-floor travel, timed door stops.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter  int WIDTH       = 5,
  parameter  int MOVE_CYCLES = 4,
  parameter  int DOOR_CYCLES = 3,
  localparam int FLW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] off,
  output logic [FLW-1:0]   floor,
  output logic             dir,
  output logic             moving,
  output logic             door_open
);

  localparam int TW = $clog2(max_int(MOVE_CYCLES, DOOR_CYCLES) + 1);

  state_t           state_r;
  state_t           state_s;
  logic [FLW-1:0]   floor_s;
  logic             dir_s;
  logic [WIDTH-1:0] off_s;
  logic             above_s;
  logic             below_s;
  logic             here_s;
  logic             load_s;
  logic [TW-1:0]    load_val_s;
  logic             en_s;
  logic [TW-1:0]    count_s;
  logic             zero_s;

  elev_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (en_s),
    .count    (count_s),
    .zero     (zero_s)
  );

  // Request masks relative to the current floor.
  always_comb begin
    above_s = 1'b0;
    below_s = 1'b0;
    here_s  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (FLW'(i) > floor) begin
        above_s = above_s | req[i];
      end else if (FLW'(i) < floor) begin
        below_s = below_s | req[i];
      end else begin
        here_s = req[i];
      end
    end
  end

  // Next-state, timer control and next registered outputs.
  always_comb begin
    state_s    = state_r;
    floor_s    = floor;
    dir_s      = dir;
    load_s     = 1'b0;
    load_val_s = '0;
    en_s       = 1'b0;
    off_s      = '0;
    case (state_r)
      ST_IDLE: begin
        // A stop here beats travel; otherwise keep sweeping, reversing only when nothing lies ahead.
        if (here_s) begin
          state_s    = ST_DOOR;
          load_s     = 1'b1;
          load_val_s = TW'(DOOR_CYCLES - 1);
        end else if ((dir == DIR_UP) && above_s) begin
          state_s    = ST_MOVE;
          load_s     = 1'b1;
          load_val_s = TW'(MOVE_CYCLES - 1);
        end else if ((dir == DIR_UP) && below_s) begin
          state_s    = ST_MOVE;
          dir_s      = DIR_DOWN;
          load_s     = 1'b1;
          load_val_s = TW'(MOVE_CYCLES - 1);
        end else if ((dir == DIR_DOWN) && below_s) begin
          state_s    = ST_MOVE;
          load_s     = 1'b1;
          load_val_s = TW'(MOVE_CYCLES - 1);
        end else if ((dir == DIR_DOWN) && above_s) begin
          state_s    = ST_MOVE;
          dir_s      = DIR_UP;
          load_s     = 1'b1;
          load_val_s = TW'(MOVE_CYCLES - 1);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (zero_s) begin
          state_s = ST_IDLE;
          floor_s = (dir == DIR_UP) ? (floor + FLW'(1)) : (floor - FLW'(1));
        end else begin
          en_s = 1'b1;
        end
      end
      ST_DOOR: begin
        if (count_s == '0) begin
          state_s = ST_IDLE;
        end else begin
          en_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (state_s == ST_DOOR) begin
      off_s[floor_s] = 1'b1;
    end else begin
      off_s = '0;
    end
  end

  // State and output registers; reset homes the car to floor 0 heading up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      floor     <= '0;
      dir       <= DIR_UP;
      off       <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state_r   <= state_s;
      floor     <= floor_s;
      dir       <= dir_s;
      off       <= off_s;
      moving    <= (state_s == ST_MOVE);
      door_open <= (state_s == ST_DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios plus random presses against a cycle-level behavioural model.
module tb_elevator_ctrl;

  localparam int WIDTH = 5;
  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 3;
  localparam int FLW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] req = '0;
  logic [WIDTH-1:0] off;
  logic [FLW-1:0]   floor;
  logic             dir;
  logic             moving;
  logic             door_open;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_MOVE, M_DOOR} mmode_t;
  mmode_t m_mode  = M_IDLE;
  int     m_floor = 0;
  int     m_dir   = 1;
  int     m_rem   = 0;

  elevator_ctrl #(
    .WIDTH       (WIDTH),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .off       (off),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_off();
    return (m_mode == M_DOOR) ? (32'd1 << m_floor) : 32'd0;
  endfunction

  // Behavioural model: m_rem is the number of cycles left in the current MOVE/DOOR phase.
  task automatic model_step(input logic r, input logic [WIDTH-1:0] rq);
    logic [31:0] rq32;
    logic        above;
    logic        below;
    logic        here;
    rq32 = 32'(rq);
    if (r) begin
      m_mode = M_IDLE; m_floor = 0; m_dir = 1; m_rem = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        above = ((rq32 >> (m_floor + 1)) != 32'd0);
        below = ((rq32 & ((32'd1 << m_floor) - 32'd1)) != 32'd0);
        here  = rq32[m_floor];
        if (here) begin
          m_mode = M_DOOR; m_rem = DOOR_CYCLES;
        end else if (above || below) begin
          if (m_dir == 1 && !above) m_dir = 0;
          else if (m_dir == 0 && !below) m_dir = 1;
          m_mode = M_MOVE; m_rem = MOVE_CYCLES;
        end
      end
      M_MOVE: begin
        m_rem--;
        if (m_rem == 0) begin
          m_floor = m_floor + ((m_dir == 1) ? 1 : -1);
          m_mode  = M_IDLE;
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: DUT and model advance on the same req, outputs compared on the falling edge, latch cleared by off.
  task automatic cycle();
    @(posedge clk);
    model_step(rst, req);
    @(negedge clk);
    check("floor", 32'(floor), 32'(m_floor));
    check("dir", 32'(dir), 32'(m_dir));
    check("moving", 32'(moving), (m_mode == M_MOVE) ? 32'd1 : 32'd0);
    check("door_open", 32'(door_open), (m_mode == M_DOOR) ? 32'd1 : 32'd0);
    check("off", 32'(off), exp_off());
    req = req & ~WIDTH'(exp_off());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic settle(input int limit);
    int n;
    n = 0;
    while (!(m_mode == M_IDLE && req == '0) && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    assert (m_mode == M_IDLE && req == '0) else begin
      errors++;
      $error("FAIL settle_timeout observed %0d cycles expected under %0d", n, limit);
    end
    cycle();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    run(2);
    check("reset_floor", 32'(floor), 32'd0);
    check("reset_dir", 32'(dir), 32'd1);
    rst = 1'b0;

    // Request at the current floor: door for DOOR_CYCLES, floor stays 0.
    req = req | 5'b00001;
    run(6);
    settle(20);

    // Three floors up: door opens 3*(MOVE_CYCLES+1) cycles after the decision edge.
    req = req | 5'b01000;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!door_open && n < 40);
    check("latency_to_door", 32'(n), 32'(3 * (MOVE_CYCLES + 1) + 1));
    check("latency_off", 32'(off), 32'h08);

    // Press again on the final door cycle at floor 3: door reopens.
    n = 0;
    while (!(m_mode == M_DOOR && m_rem == 1) && n < 10) begin
      cycle();
      n++;
    end
    req = req | 5'b01000;
    run(2);
    check("reopen_door", 32'(door_open), 32'd1);
    settle(20);

    // Down to 2, on to 0, back up to 2 so the car sits at 2 heading up.
    req = req | 5'b00100;
    settle(30);
    req = req | 5'b00001;
    settle(30);
    req = req | 5'b00100;
    settle(30);
    check("at2_up_dir", 32'(dir), 32'd1);

    // Both ends pending at 2 going up: top served first, then bottom.
    req = req | 5'b10001;
    settle(60);
    check("scan_up_end_floor", 32'(floor), 32'd0);

    // Back to 2 heading up, then reset in the second MOVE cycle toward 3.
    req = req | 5'b00100;
    settle(30);
    req = req | 5'b10000;
    cycle();
    cycle();
    check("second_move_cycle", 32'(moving), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = '0;
    check("rst_mid_floor", 32'(floor), 32'd0);
    check("rst_mid_moving", 32'(moving), 32'd0);
    check("rst_mid_dir", 32'(dir), 32'd1);

    // Reach 2 heading down, then both ends pending: bottom first.
    req = req | 5'b01000;
    settle(30);
    req = req | 5'b00100;
    settle(30);
    check("at2_down_dir", 32'(dir), 32'd0);
    req = req | 5'b10001;
    settle(60);
    check("scan_down_end_floor", 32'(floor), 32'd4);

    // Random presses with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = req | WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    settle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
